// File: rtl/fetch_redirect.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_redirect
//  Purpose  : Fetch-stage PC, imem drive and IF/ID register with squash of
//             wrong-path words after an execute-stage jump/branch redirect.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_redirect #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned SQUASH   = 1,
    parameter logic [15:0] NOP      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        SelectJOrB,
    input  logic [15:0] JBTarget,
    input  logic [15:0] ImemInstr,
    output logic [15:0] ImemAddr,
    output logic        ImemEn,
    output logic [15:0] IfInstr,
    output logic [15:0] IfPC,
    output logic        IfValid,
    output logic        Misalign,
    output logic [15:0] RedirectCount
);

    localparam logic [1:0]  c_SQUASH_INIT = SQUASH[1:0];
    localparam logic [15:0] c_COUNT_MAX   = 16'hFFFF;

    logic [15:0] r_pc;
    logic [15:0] r_pcIssued;
    logic [1:0]  r_sqCnt;
    logic [15:0] r_ifInstr;
    logic [15:0] r_ifPc;
    logic        r_ifValid;
    logic        r_misalign;
    logic [15:0] r_redirectCount;

    logic        w_squashing;
    logic [15:0] w_pcNext;

    assign w_squashing = (r_sqCnt != 2'd0);
    assign w_pcNext    = r_pc + 16'd2;

    // A redirect must reach the imem even while decode is holding.
    assign ImemEn   = ~stall | SelectJOrB;
    assign ImemAddr = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_pcIssued      <= RESET_PC;
            r_sqCnt         <= c_SQUASH_INIT;
            r_ifInstr       <= NOP;
            r_ifPc          <= RESET_PC;
            r_ifValid       <= 1'b0;
            r_misalign      <= 1'b0;
            r_redirectCount <= 16'd0;
        end else if (SelectJOrB) begin
            r_pc       <= {JBTarget[15:1], 1'b0};
            r_pcIssued <= r_pc;
            r_sqCnt    <= c_SQUASH_INIT;
            r_ifInstr  <= NOP;
            r_ifValid  <= 1'b0;
            if (r_redirectCount != c_COUNT_MAX) begin
                r_redirectCount <= r_redirectCount + 16'd1;
            end
            if (JBTarget[0]) begin
                r_misalign <= 1'b1;
            end
        end else if (!stall) begin
            r_pc       <= w_pcNext;
            r_pcIssued <= r_pc;
            if (w_squashing) begin
                // Word on ImemInstr belongs to the path before the redirect.
                r_ifInstr <= NOP;
                r_ifValid <= 1'b0;
                r_sqCnt   <= r_sqCnt - 2'd1;
            end else begin
                r_ifInstr <= ImemInstr;
                r_ifPc    <= r_pcIssued;
                r_ifValid <= 1'b1;
            end
        end
    end

    assign IfInstr       = r_ifInstr;
    assign IfPC          = r_ifPc;
    assign IfValid       = r_ifValid;
    assign Misalign      = r_misalign;
    assign RedirectCount = r_redirectCount;

endmodule
`default_nettype wire
